// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier: datapath width,
// iteration count, FSM encoding and the operand magnitude helper.
package seq_multiplier_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned MUL_ITER = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } mul_state_e;

  // |x| = ~x + 1 when treated as signed and negative; 0x80000000 maps to itself (2^31).
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x, input logic en);
    return (en && x[XLEN-1]) ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Start/done handshake and operand/result bus of the sequential multiplier.
interface seq_multiplier_if;
  import seq_multiplier_pkg::*;

  logic              start;
  logic              is_signed;
  logic [XLEN-1:0]   a;
  logic [XLEN-1:0]   b;
  logic              ready;
  logic              done;
  logic [2*XLEN-1:0] product;

  modport master (
    output start, is_signed, a, b,
    input  ready, done, product
  );

  modport slave (
    input  start, is_signed, a, b,
    output ready, done, product
  );

endinterface

// File: rtl/seq_multiplier_adder.sv
// 32-bit combinational adder with carry-out; the multiplier's single add resource.
module seq_multiplier_adder
  import seq_multiplier_pkg::*;
(
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic [XLEN-1:0] S,
  output logic            C
);

  assign {C, S} = {1'b0, A} + {1'b0, B};

endmodule

// File: rtl/seq_multiplier.sv
// Fixed-latency (34-cycle) 32x32 shift-and-add multiplier, signed or unsigned, with
// magnitude pre-conversion and a final sign fix-up.
module seq_multiplier
  import seq_multiplier_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  seq_multiplier_if.slave    bus
);

  mul_state_e        state_q;
  logic [4:0]        cnt_q;
  logic [XLEN-1:0]   p_hi_q;
  logic [XLEN-1:0]   p_lo_q;
  logic [XLEN-1:0]   mcand_q;
  logic              neg_q;
  logic              ready_q;
  logic              done_q;
  logic [2*XLEN-1:0] product_q;

  logic [XLEN-1:0]   add_b;
  logic [XLEN-1:0]   add_s;
  logic              add_c;
  logic [2*XLEN-1:0] fixed_d;

  always_comb begin
    add_b   = p_lo_q[0] ? mcand_q : '0;
    fixed_d = neg_q ? (~{p_hi_q, p_lo_q} + 64'd1) : {p_hi_q, p_lo_q};
  end

  seq_multiplier_adder u_add (
    .A (p_hi_q),
    .B (add_b),
    .S (add_s),
    .C (add_c)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      p_hi_q    <= '0;
      p_lo_q    <= '0;
      mcand_q   <= '0;
      neg_q     <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (bus.start) begin
            mcand_q <= magnitude(bus.a, bus.is_signed);
            p_lo_q  <= magnitude(bus.b, bus.is_signed);
            p_hi_q  <= '0;
            cnt_q   <= '0;
            neg_q   <= bus.is_signed & (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
            ready_q <= 1'b0;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          // 65-bit right shift keeps the adder carry in the top bit.
          {p_hi_q, p_lo_q} <= {add_c, add_s, p_lo_q[XLEN-1:1]};
          cnt_q            <= cnt_q + 5'd1;
          if (cnt_q == 5'(MUL_ITER - 1)) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          product_q <= fixed_d;
          done_q    <= 1'b1;
          ready_q   <= 1'b1;
          state_q   <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ready   = ready_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench: directed corner cases plus random operands against a 64-bit
// arithmetic reference.
module tb_seq_multiplier;

  logic clk_i = 1'b0;
  logic rst_ni;

  seq_multiplier_if bus ();

  seq_multiplier dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] last_prod;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    logic signed [63:0] sa, sb;
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      return sa * sb;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Called with the DUT ready; leaves the bench #1 after the edge that raised done.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input bit inject, input string tag);
    int lat;
    int ndone;
    logic [63:0] exp;
    exp = ref_mul(a, b, s);
    check_val({tag, ".ready_in"}, {63'd0, bus.ready}, 64'd1);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.is_signed = s;
    tick();
    bus.start = 1'b0;
    lat = 1;
    ndone = 0;
    while (!bus.done && lat < 60) begin
      if (lat == 5) begin
        check_val({tag, ".ready_run"}, {63'd0, bus.ready}, 64'd0);
        check_val({tag, ".prod_held"}, bus.product, last_prod);
      end
      if (inject && lat == 10) begin
        bus.start = 1'b1; bus.a = ~a; bus.b = b + 32'd7; bus.is_signed = ~s;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      lat++;
    end
    check_val({tag, ".latency"}, 64'(lat), 64'd34);
    check_val({tag, ".product"}, bus.product, exp);
    last_prod = exp;
  endtask

  task automatic step_idle(input string tag);
    tick();
    check_val({tag, ".done_pulse"}, {63'd0, bus.done}, 64'd0);
    check_val({tag, ".ready_idle"}, {63'd0, bus.ready}, 64'd1);
    check_val({tag, ".prod_keep"}, bus.product, last_prod);
  endtask

  initial begin
    int seen_done;
    rst_ni = 1'b0;
    bus.start = 1'b0; bus.is_signed = 1'b0; bus.a = '0; bus.b = '0;
    last_prod = '0;
    repeat (3) tick();
    rst_ni = 1'b1;
    check_val("rst.ready", {63'd0, bus.ready}, 64'd1);
    check_val("rst.done", {63'd0, bus.done}, 64'd0);
    check_val("rst.product", bus.product, 64'd0);

    run_op(32'd2, 32'hFFFF_FFFE, 1'b0, 1'b0, "u2xfe");
    step_idle("u2xfe");
    run_op(32'd2, 32'hFFFF_FFFE, 1'b1, 1'b0, "s2xm2");
    step_idle("s2xm2");
    run_op(32'd56, 32'd44, 1'b0, 1'b0, "u56x44");
    run_op(32'd99, 32'd4, 1'b0, 1'b0, "b2b99x4");
    step_idle("b2b99x4");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "umax");
    step_idle("umax");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, "sm1");
    step_idle("sm1");
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, "sminsq");
    step_idle("sminsq");
    run_op(32'h8000_0000, 32'd1, 1'b1, 1'b0, "smin1");
    step_idle("smin1");
    run_op(32'd12345, 32'd678, 1'b1, 1'b1, "ignore");
    step_idle("ignore");

    // Reset 20 cycles into RUN: no done may appear afterwards.
    bus.start = 1'b1; bus.a = 32'd77; bus.b = 32'd88; bus.is_signed = 1'b0;
    tick();
    bus.start = 1'b0;
    repeat (19) tick();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    last_prod = '0;
    check_val("midrst.ready", {63'd0, bus.ready}, 64'd1);
    check_val("midrst.product", bus.product, 64'd0);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) seen_done++;
      tick();
    end
    check_val("midrst.no_done", 64'(seen_done), 64'd0);
    run_op(32'd3, 32'hFFFF_FFFB, 1'b1, 1'b0, "s3xm5");
    step_idle("s3xm5");

    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra, rb;
      logic rs;
      ra = $urandom();
      rb = $urandom();
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'd0;
        default: ;
      endcase
      run_op(ra, rb, rs, 1'b0, $sformatf("rnd%0d", i));
      if (i % 3 != 0) step_idle($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Multi-cycle 32×32 shift-and-add multiplier for the ALU's MUL path, producing a 64-bit product. Each cycle it feeds operands into one instance of the existing 32-bit `ADDER` and consumes the sum and carry-out to build the product. It has a start/done handshake, supports signed and unsigned operands, and has fixed latency, so the control unit can stall deterministically.

## Interface
- Parameters: none. The datapath is fixed at 32 bits to match `ADDER`.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request a multiply. Sampled only while `ready`=1.
- `is_signed`  in  1  1 selects two's-complement operands, 0 selects unsigned. Sampled with `start`.
- `a`  in  32  multiplicand. Sampled with `start`.
- `b`  in  32  multiplier. Sampled with `start`.
- `ready`  out  1  high in IDLE and DONE. A new `start` is accepted only when this is high.
- `done`  out  1  one-cycle pulse; `product` is valid from this cycle onward.
- `product`  out  64  result. Held until the next accepted `start`.

## Operation
- States:
  - IDLE: `ready`=1, `done`=0.
  - RUN: 32 iterations, controlled by a 5-bit counter.
  - FIX: sign correction.
  - DONE: `ready`=1, `done`=1.
- IDLE or DONE with `start`=1 goes to RUN. At that edge the block latches:
  - `mcand` = |a| if `is_signed` and a[31]=1, else a.
  - `P_lo` = |b| under the same rule, else b.
  - `P_hi` = 0 and `cnt` = 0.
  - `neg` = `is_signed` & (a[31] ^ b[31]).
- Magnitude rule: |x| = ~x + 1 in 32 bits. |0x80000000| = 0x80000000, read as unsigned 2^31.
- RUN iteration:
  - `ADDER.A` = `P_hi`; `ADDER.B` = `P_lo[0]` ? `mcand` : 0.
  - Next value: {`P_hi`, `P_lo`} = {`C`, `S`, `P_lo[31:1]`}. This is a 65-bit right shift that keeps the carry.
  - `cnt` increments. When `cnt`=31, the next state is FIX.
- FIX: `product` = `neg` ? (~{`P_hi`, `P_lo`} + 1) : {`P_hi`, `P_lo`}. The 64-bit increment is inline logic and does not use `ADDER`. Next state is DONE.
- DONE: `done`=1 for exactly one cycle.
  - Next state is RUN if `start`=1 in this cycle, otherwise IDLE.
  - `product` keeps its value in IDLE.
- `start` in RUN or FIX is ignored. It is not queued and the operands are not re-latched.
- `product` is overwritten only in FIX. It keeps its old value during RUN of the next operation.

## Timing
- Reset (`rst_n`=0 at an edge) clears the following, regardless of the current state, including mid-RUN and FIX:
  - State goes to IDLE; `ready`=1, `done`=0, `product`=0.
  - `cnt`, `P_hi`, `P_lo`, `mcand` and `neg` go to 0.
  - An operation in flight is discarded without a `done` pulse.
- Latency: `start` sampled at edge k puts the block in RUN for edges k+1..k+32. FIX occurs at edge k+33. `done` is high in the cycle after edge k+33, so latency is 34 cycles.
- Latency is identical for signed and unsigned operands and for all operand values. There is no early termination.
- Back-to-back: `start` asserted in the DONE cycle is accepted. Throughput is one result per 34 cycles.
- `ADDER` is purely combinational. Its `S` and `C` are registered only into `P_hi` and the carry position. No combinational path exists from inputs to outputs.

## Structure
- Shared ALU package: state encoding constants (IDLE, RUN, FIX, DONE as 2-bit localparams), `XLEN`=32 and `MUL_ITER`=32.
- One sub-module: the existing `ADDER`, instantiated once as `u_add` with ports A, B, S and C.
- Everything else sits in this module: magnitude/negate logic, FSM, counter and shift register.

## Test plan
- Reset, then a=2, b=0xFFFFFFFE, unsigned -> `done` at cycle 34, `product`=0x00000001_FFFFFFFC. The same operands signed -> 0xFFFFFFFF_FFFFFFFC (-4).
- a=56, b=44 unsigned -> 0x9A0. Then a=99, b=4 issued in the DONE cycle -> accepted, 34 cycles later `product`=0x18C.
- a=b=0xFFFFFFFF unsigned -> 0xFFFFFFFE_00000001. Signed -> 1.
- a=b=0x80000000 signed -> 0x40000000_00000000. a=0x80000000, b=1 signed -> 0xFFFFFFFF_80000000.
- `start` pulsed with new operands at cycle 10 of RUN -> ignored, the original result is returned, and `done` pulses once.
- `rst_n`=0 at cycle 20 of RUN -> the next cycle shows `ready`=1 and `product`=0, and no `done` pulse occurs. A fresh a=3, b=-5 signed then completes with 0xFFFFFFFF_FFFFFFF1.
